// File: rtl/alu_seq_muldiv.sv
// Multi-cycle ALU: single-cycle base ops plus
// iterative shift-add multiply and restoring divide.
module alu_seq_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MINV =
    {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULH  = 4'b1001;
  localparam logic [3:0] OP_MULHU = 4'b1010;
  localparam logic [3:0] OP_DIV   = 4'b1011;
  localparam logic [3:0] OP_DIVU  = 4'b1100;
  localparam logic [3:0] OP_REM   = 4'b1101;
  localparam logic [3:0] OP_REMU  = 4'b1110;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [3:0]         op_q;
  logic               neg_q;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dvsr;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH:0]     rem;

  logic             is_mul, is_div, sgn_in;
  logic             div0, ovf, special, neg_in;
  logic [WIDTH-1:0] a_op, b_op, imm_res;

  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] acc_nx, acc_sg;
  logic [WIDTH:0]     rsh, diff, rem_nx;
  logic [WIDTH-1:0]   quo_nx, fin_res;

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Decode the incoming op and resolve single-cycle results
  always_comb begin
    is_mul  = (ALUControl == OP_MUL) |
              (ALUControl == OP_MULH) |
              (ALUControl == OP_MULHU);
    is_div  = (ALUControl >= OP_DIV) &
              (ALUControl <= OP_REMU);
    sgn_in  = (ALUControl == OP_MULH) |
              (ALUControl == OP_DIV) |
              (ALUControl == OP_REM);
    a_op    = (sgn_in && A[WIDTH-1]) ? -A : A;
    b_op    = (sgn_in && B[WIDTH-1]) ? -B : B;
    div0    = (B == '0);
    ovf     = ((ALUControl == OP_DIV) |
               (ALUControl == OP_REM)) &
              (A == MINV) & (B == '1);
    special = is_div & (div0 | ovf);
    neg_in  = 1'b0;
    if (ALUControl == OP_REM)
      neg_in = A[WIDTH-1];
    else if (sgn_in)
      neg_in = A[WIDTH-1] ^ B[WIDTH-1];
    imm_res = '0;
    case (ALUControl)
      4'b0000: imm_res = A + B;
      4'b0001: imm_res = A - B;
      4'b0010: imm_res = A & B;
      4'b0011: imm_res = A | B;
      4'b0100: imm_res = {{(WIDTH-1){1'b0}},
                 ($signed(A) < $signed(B))};
      4'b0101: imm_res = A - B;
      4'b0110: imm_res = A ^ B;
      4'b0111: imm_res = {{(WIDTH-1){1'b0}},
                 (A < B)};
      OP_DIV:  imm_res = div0 ? '1 : MINV;
      OP_DIVU: imm_res = '1;
      OP_REM:  imm_res = div0 ? A : '0;
      OP_REMU: imm_res = A;
      default: imm_res = '0;
    endcase
  end

  // One multiply and one divide iteration, plus final sign fixup
  always_comb begin
    msum   = {1'b0, acc[2*WIDTH-1:WIDTH]} +
             {1'b0, (acc[0] ? mcand : '0)};
    acc_nx = {msum, acc[WIDTH-1:1]};
    acc_sg = neg_q ? -acc_nx : acc_nx;
    rsh    = {rem[WIDTH-1:0], quo[WIDTH-1]};
    diff   = rsh - {1'b0, dvsr};
    if (!diff[WIDTH]) begin
      rem_nx = diff;
      quo_nx = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_nx = rsh;
      quo_nx = {quo[WIDTH-2:0], 1'b0};
    end
    case (op_q)
      OP_MUL:   fin_res = acc_nx[WIDTH-1:0];
      OP_MULH:  fin_res = acc_sg[2*WIDTH-1:WIDTH];
      OP_MULHU: fin_res = acc_nx[2*WIDTH-1:WIDTH];
      OP_DIV,
      OP_DIVU:  fin_res = neg_q ? -quo_nx : quo_nx;
      OP_REM,
      OP_REMU:  fin_res = neg_q ?
                  -rem_nx[WIDTH-1:0] :
                  rem_nx[WIDTH-1:0];
      default:  fin_res = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic; flush always returns to idle
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (start && !flush) begin
          if (is_mul)
            state_nx = S_MUL;
          else if (is_div && !special)
            state_nx = S_DIV;
          else
            state_nx = S_DONE;
        end
      end
      S_MUL, S_DIV: begin
        if (flush)
          state_nx = S_IDLE;
        else if (cnt == '0)
          state_nx = S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Operand capture, iteration registers and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      neg_q     <= 1'b0;
      cnt       <= '0;
      mcand     <= '0;
      acc       <= '0;
      dvsr      <= '0;
      quo       <= '0;
      rem       <= '0;
      ALUResult <= '0;
      zero      <= 1'b0;
    end else if (!flush) begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q  <= ALUControl;
            neg_q <= neg_in;
            cnt   <= CW'(WIDTH - 1);
            mcand <= b_op;
            acc   <= {{WIDTH{1'b0}}, a_op};
            dvsr  <= b_op;
            quo   <= a_op;
            rem   <= '0;
            if (!(is_mul || (is_div && !special))) begin
              ALUResult <= imm_res;
              zero      <= (imm_res == '0);
            end
          end
        end
        S_MUL, S_DIV: begin
          acc <= acc_nx;
          quo <= quo_nx;
          rem <= rem_nx;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            ALUResult <= fin_res;
            zero      <= (fin_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed bench for alu_seq_muldiv (WIDTH=32):
// latency, results, flush, ignored start, async reset.
module tb_alu_seq_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, flush;
  logic [3:0]  ALUControl;
  logic [31:0] A, B;
  logic        busy, done, zero;
  logic [31:0] ALUResult;

  int nchk = 0;
  int nerr = 0;

  alu_seq_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .start(start), .flush(flush),
    .ALUControl(ALUControl),
    .A(A), .B(B),
    .busy(busy), .done(done),
    .ALUResult(ALUResult), .zero(zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // Launch at edge 0; return one step into cycle 1
  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    ALUControl = op; A = a; B = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = $urandom; B = $urandom;
    ALUControl = 4'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run(input string tag,
                     input logic [3:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input logic [31:0] er,
                     input logic ez,
                     input int el);
    int lat;
    issue(op, a, b);
    wait_done(lat);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_res"}, ALUResult, er);
    chk({tag, "_z"}, {31'b0, zero}, {31'b0, ez});
    @(posedge clk); #1;
    chk({tag, "_dn"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int ndone, dcyc;
    logic ok;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0;
    ALUControl = '0; A = '0; B = '0;
    #12;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_res", ALUResult, 0);
    chk("rst_zero", {31'b0, zero}, 0);
    @(negedge clk); rst_n = 1'b1;

    run("add", 4'b0000, 1, 1, 2, 0, 1);
    run("beq", 4'b0101, 5, 5, 0, 1, 1);
    run("sub", 4'b0001, 3, 5, 32'hFFFF_FFFE, 0, 1);
    run("and", 4'b0010, 32'hF0F0, 32'hFF00,
        32'hF000, 0, 1);
    run("or", 4'b0011, 32'hF0, 32'h0F, 32'hFF, 0, 1);
    run("xor", 4'b0110, 32'hFF, 32'hFF, 0, 1, 1);
    run("slt", 4'b0100, 32'hFFFF_FFFF, 1, 1, 0, 1);
    run("sltu", 4'b0111, 32'hFFFF_FFFF, 1, 0, 1, 1);
    run("inv", 4'b1111, 9, 9, 0, 1, 1);
    run("addw", 4'b0000, 32'hFFFF_FFFF, 1, 0, 1, 1);

    run("mul", 4'b1000, 32'hFFFF_FFFF, 2,
        32'hFFFF_FFFE, 0, 33);
    run("mulh", 4'b1001, 32'hFFFF_FFFF, 2,
        32'hFFFF_FFFF, 0, 33);
    run("mulhu", 4'b1010, 32'hFFFF_FFFF, 2, 1, 0, 33);
    run("mul76", 4'b1000, 7, 6, 42, 0, 33);
    run("mulhmin", 4'b1001, 32'h8000_0000,
        32'h8000_0000, 32'h4000_0000, 0, 33);

    run("div", 4'b1011, 32'hFFFF_FFF9, 2,
        32'hFFFF_FFFD, 0, 33);
    run("rem", 4'b1101, 32'hFFFF_FFF9, 2,
        32'hFFFF_FFFF, 0, 33);
    run("divneg", 4'b1011, 7, 32'hFFFF_FFFE,
        32'hFFFF_FFFD, 0, 33);
    run("remneg", 4'b1101, 7, 32'hFFFF_FFFE, 1, 0, 33);
    run("divu", 4'b1100, 100, 7, 14, 0, 33);
    run("remu", 4'b1110, 100, 7, 2, 0, 33);
    run("divu0", 4'b1100, 7, 0, 32'hFFFF_FFFF, 0, 1);
    run("remu0", 4'b1110, 7, 0, 7, 0, 1);
    run("divovf", 4'b1011, 32'h8000_0000,
        32'hFFFF_FFFF, 32'h8000_0000, 0, 1);
    run("removf", 4'b1101, 32'h8000_0000,
        32'hFFFF_FFFF, 0, 1, 1);

    // busy window of a multiply
    issue(4'b1000, 32'hFFFF_FFFF, 2);
    ok = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      if (!busy || done) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("mul_busywin", {31'b0, ok}, 1);
    chk("mul_done33", {31'b0, done}, 1);
    chk("mul_busy33", {31'b0, busy}, 1);
    @(posedge clk); #1;
    chk("mul_idle", {31'b0, busy}, 0);

    // start pulses while dividing are ignored
    issue(4'b1100, 100, 7);
    ndone = 0; dcyc = 0;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin ndone++; dcyc = c; end
      if (c == 5 || c == 10) begin
        start = 1'b1; ALUControl = 4'b0000;
        A = 1; B = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("ign_ndone", ndone, 1);
    chk("ign_dcyc", dcyc, 33);
    chk("ign_res", ALUResult, 14);

    // flush mid-multiply
    issue(4'b1000, 3, 3);
    for (int c = 1; c < 10; c++) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("fl_busy", {31'b0, busy}, 0);
    chk("fl_done", {31'b0, done}, 0);
    chk("fl_res", ALUResult, 14);
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("fl_nodone", ndone, 0);

    // flush together with start drops the start
    @(negedge clk);
    start = 1'b1; flush = 1'b1;
    ALUControl = 4'b0000; A = 1; B = 1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flst_busy", {31'b0, busy}, 0);
    chk("flst_done", {31'b0, done}, 0);

    // asynchronous reset mid-multiply
    issue(4'b1000, 32'hFFFF_FFFF, 2);
    for (int c = 1; c < 5; c++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", {31'b0, busy}, 0);
    chk("ar_done", {31'b0, done}, 0);
    chk("ar_res", ALUResult, 0);
    chk("ar_zero", {31'b0, zero}, 0);
    @(negedge clk); rst_n = 1'b1;
    run("ar_add", 4'b0000, 1, 1, 2, 0, 1);
    run("ar_mul", 4'b1000, 7, 6, 42, 0, 33);

    $display("TB_RESULT checks=%0d failures=%0d",
             nchk, nerr);
    $finish;
  end

endmodule
